runway_lights: RTL and testbench
================================

RUNWAY_LIGHTS -- requirements
Module: runway_lights

Interface
REQ-001 SHALL have parameter N_LIGHTS, default 3: number of lamps, legal range >= 2; lights[N_LIGHTS-1] is the leftmost lamp.
REQ-002 SHALL have parameter TICK_DIV, default 1: clk cycles per pattern step, legal range >= 1.
REQ-003 SHALL have parameter HAZARD_BLINK, default 0: 0 = hazard solid on, 1 = hazard blinks.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port wind_l, input, 1 bit: wind from left, so the pattern sweeps left-to-right.
REQ-007 SHALL have port wind_r, input, 1 bit: wind from right, so the pattern sweeps right-to-left.
REQ-008 SHALL have port lights, output, N_LIGHTS bits: registered lamp drive, 1 = on.
REQ-009 SHALL have port mode, output, 2 bits: registered current mode; 00 CALM, 01 R2L, 10 L2R, 11 HAZARD.
REQ-010 SHALL have port step, output, 1 bit: high for exactly the cycle after each lights/mode update edge.

Function
REQ-011 SHALL keep a divider count div_cnt (0..TICK_DIV-1): +1 per cycle, wraps to 0; tick = (div_cnt == TICK_DIV-1); TICK_DIV=1 means a tick every cycle.
REQ-012 SHALL sample wind_l/wind_r only on tick cycles and ignore them on all other cycles.
REQ-013 SHALL decode the sampled inputs as: 00 -> CALM, 10 -> L2R, 01 -> R2L, 11 -> HAZARD.
REQ-014 SHALL, on a tick edge where the decoded mode differs from mode, load the entry pattern of the new mode: CALM = PA; L2R = one-hot at bit N_LIGHTS-1; R2L = one-hot at bit 0; HAZARD = all ones.
REQ-015 SHALL define PA as lamps i where (N_LIGHTS-1-i) is even, and PB as ~PA (N_LIGHTS bits).
REQ-016 SHALL, on a tick edge where the decoded mode equals mode, advance the pattern:
- CALM: PA <-> PB toggle.
- L2R: one-hot shifts one place toward bit 0; after bit 0, wraps to bit N_LIGHTS-1.
- R2L: one-hot shifts one place toward bit N_LIGHTS-1; after bit N_LIGHTS-1, wraps to bit 0.
- HAZARD, HAZARD_BLINK=0: stays all ones.
- HAZARD, HAZARD_BLINK=1: toggles all ones <-> all zeros.
REQ-017 SHALL update lights and mode only on tick edges, holding both between ticks.
REQ-018 SHALL assert step on the cycle after every tick edge, including edges where the pattern value is unchanged (solid hazard).
REQ-019 SHALL leave exactly one lamp on at all times in L2R/R2L, and never leave an X or all-zero pattern outside blinking hazard.
REQ-020 SHALL handle a direction reversal (L2R <-> R2L) as a mode change per REQ-014: restart at the entry lamp with no carried position.
REQ-021 SHALL treat leaving HAZARD the same as any other mode change: the entry pattern of the new mode.

Reset
REQ-022 SHALL, on a reset edge, set lights = all ones, mode = 11 (HAZARD), div_cnt = 0, step = 0, and the blink phase to "on".
REQ-023 SHALL give reset priority over tick, including when reset is asserted mid-sweep or mid-divide; the first tick after release is TICK_DIV cycles after the release edge.

Verification
REQ-024 SHALL cover: N=3, TICK_DIV=1, reset then {0,0} for 4 cycles -> lights 111, 101, 010, 101, 010; mode 00.
REQ-025 SHALL cover: N=3, TICK_DIV=1, {1,0} for 4 cycles -> 100, 010, 001, 100; then {0,1} -> 001 (restart), 010.
REQ-026 SHALL cover: N=8, TICK_DIV=4, {0,1} held 40 cycles -> one-hot walks 0x01 .. 0x80 then 0x01, changing only every 4th cycle; step high once per 4 cycles.
REQ-027 SHALL cover: N=8, TICK_DIV=4, inputs toggled between ticks and restored before the tick -> no mode or pattern change.
REQ-028 SHALL cover: HAZARD_BLINK=1, {1,1} after calm -> 0xFF, 0x00, 0xFF; with HAZARD_BLINK=0 -> 0xFF held, step still pulsing.
REQ-029 SHALL cover: reset asserted mid-L2R with div_cnt != 0 -> next cycle lights all ones, mode 11, step 0; first update TICK_DIV cycles after release.

Source files
------------

// File: rtl/runway_lights.sv
// runway_lights -- wind-direction lamp sequencer for a row of runway lamps.
//
// A divider produces one tick every TICK_DIV clocks. On each tick the wind
// inputs are sampled and decoded into a mode. If the decoded mode differs
// from the current one, the new mode's entry pattern is loaded. If it is the
// same, the current pattern advances one step. Between ticks everything holds.
//
// Parameters:
//   N_LIGHTS     number of lamps (>= 2); lights[N_LIGHTS-1] is the leftmost
//   TICK_DIV     clk cycles per pattern step (>= 1)
//   HAZARD_BLINK 0 = hazard solid on, 1 = hazard blinks all-on/all-off
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high; forces HAZARD with all lamps on
//   wind_l  wind from the left  (pattern sweeps left-to-right)
//   wind_r  wind from the right (pattern sweeps right-to-left)
//   lights  registered lamp drive, 1 = on
//   mode    registered mode (also the FSM state): 00 CALM, 01 R2L, 10 L2R, 11 HAZARD
//   step    high for the one cycle after each tick (update) edge
module runway_lights #(
  parameter int N_LIGHTS     = 3,
  parameter int TICK_DIV     = 1,
  parameter int HAZARD_BLINK = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wind_l,
  input  logic                wind_r,
  output logic [N_LIGHTS-1:0] lights,
  output logic [1:0]          mode,
  output logic                step
);

  typedef enum logic [1:0] {
    MODE_CALM   = 2'b00,
    MODE_R2L    = 2'b01,
    MODE_L2R    = 2'b10,
    MODE_HAZARD = 2'b11
  } mode_e;

  // At least one divider bit, even when TICK_DIV is 1 and the counter sits at 0.
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  // Calm pattern A: lamps whose distance from the leftmost lamp is even.
  function automatic logic [N_LIGHTS-1:0] calc_pa();
    logic [N_LIGHTS-1:0] pa;
    pa = '0;
    for (int i = 0; i < N_LIGHTS; i++) begin
      if (((N_LIGHTS - 1 - i) % 2) == 0) pa[i] = 1'b1;
    end
    return pa;
  endfunction

  localparam logic [N_LIGHTS-1:0] PA       = calc_pa();
  localparam logic [N_LIGHTS-1:0] PB       = ~PA;
  localparam logic [N_LIGHTS-1:0] ALL_ON   = '1;
  localparam logic [N_LIGHTS-1:0] LAMP_LSB = N_LIGHTS'(1);
  localparam logic [N_LIGHTS-1:0] LAMP_MSB = {1'b1, {(N_LIGHTS-1){1'b0}}};

  mode_e               mode_q, mode_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                step_q, step_d;
  logic                tick;
  mode_e               wind_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_HAZARD;
      lights_q  <= ALL_ON;
      div_cnt_q <= '0;
      step_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      lights_q  <= lights_d;
      div_cnt_q <= div_cnt_d;
      step_q    <= step_d;
    end
  end

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    step_d    = tick;
    mode_d    = mode_q;
    lights_d  = lights_q;

    case ({wind_l, wind_r})
      2'b00:   wind_mode = MODE_CALM;
      2'b10:   wind_mode = MODE_L2R;
      2'b01:   wind_mode = MODE_R2L;
      default: wind_mode = MODE_HAZARD;
    endcase

    if (tick) begin
      if (wind_mode != mode_q) begin
        // Any mode change, including a reversal or leaving hazard, restarts
        // at the entry pattern; no position is carried across.
        mode_d = wind_mode;
        case (wind_mode)
          MODE_CALM: lights_d = PA;
          MODE_L2R:  lights_d = LAMP_MSB;
          MODE_R2L:  lights_d = LAMP_LSB;
          default:   lights_d = ALL_ON;
        endcase
      end else begin
        case (mode_q)
          // Anything other than PA goes to PA, so calm never shows all-off.
          MODE_CALM: lights_d = (lights_q == PA) ? PB : PA;
          MODE_L2R:  lights_d = lights_q[0] ? LAMP_MSB : (lights_q >> 1);
          MODE_R2L:  lights_d = lights_q[N_LIGHTS-1] ? LAMP_LSB : (lights_q << 1);
          // The lamps themselves hold the blink phase: reset and hazard
          // entry leave them all on, so inverting alternates on/off.
          default:   lights_d = (HAZARD_BLINK != 0) ? ~lights_q : ALL_ON;
        endcase
      end
    end
  end

  assign lights = lights_q;
  assign mode   = mode_q;
  assign step   = step_q;

endmodule

// File: tb/tb_runway_lights.sv
// Bench for runway_lights with three instances sharing one clock:
//   a: N_LIGHTS=3, TICK_DIV=1, solid hazard
//   b: N_LIGHTS=8, TICK_DIV=4, solid hazard
//   c: N_LIGHTS=8, TICK_DIV=1, blinking hazard
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_runway_lights;

  logic       clk;
  logic       rst_a, wl_a, wr_a;
  logic [2:0] lights_a;
  logic [1:0] mode_a;
  logic       step_a;
  logic       rst_b, wl_b, wr_b;
  logic [7:0] lights_b;
  logic [1:0] mode_b;
  logic       step_b;
  logic       rst_c, wl_c, wr_c;
  logic [7:0] lights_c;
  logic [1:0] mode_c;
  logic       step_c;

  int checks;
  int errors;
  int b_e;  // rising edges of instance b since its reset was released

  runway_lights #(.N_LIGHTS(3), .TICK_DIV(1), .HAZARD_BLINK(0)) dut_a (
    .clk(clk), .reset(rst_a), .wind_l(wl_a), .wind_r(wr_a),
    .lights(lights_a), .mode(mode_a), .step(step_a));

  runway_lights #(.N_LIGHTS(8), .TICK_DIV(4), .HAZARD_BLINK(0)) dut_b (
    .clk(clk), .reset(rst_b), .wind_l(wl_b), .wind_r(wr_b),
    .lights(lights_b), .mode(mode_b), .step(step_b));

  runway_lights #(.N_LIGHTS(8), .TICK_DIV(1), .HAZARD_BLINK(1)) dut_c (
    .clk(clk), .reset(rst_c), .wind_l(wl_c), .wind_r(wr_c),
    .lights(lights_c), .mode(mode_c), .step(step_c));

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; wl_a = 1'b0; wr_a = 1'b0;
    next_edge();
    next_edge();
    checks++;
    if (lights_a !== 3'b111) begin errors++; $display("FAIL reset_lights: got %b expected 111", lights_a); end
    checks++;
    if (mode_a !== 2'b11) begin errors++; $display("FAIL reset_mode: got %b expected 11", mode_a); end
    checks++;
    if (step_a !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", step_a); end
  endtask

  task automatic test_calm();
    logic [2:0] exp_l [4];
    exp_l = '{3'b101, 3'b010, 3'b101, 3'b010};
    rst_a = 1'b0; wl_a = 1'b0; wr_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_edge();
      checks++;
      if (lights_a !== exp_l[i]) begin errors++; $display("FAIL calm_lights[%0d]: got %b expected %b", i, lights_a, exp_l[i]); end
      checks++;
      if (mode_a !== 2'b00) begin errors++; $display("FAIL calm_mode[%0d]: got %b expected 00", i, mode_a); end
      checks++;
      if (step_a !== 1'b1) begin errors++; $display("FAIL calm_step[%0d]: got %b expected 1", i, step_a); end
    end
  endtask

  task automatic test_sweep_reverse();
    logic [2:0] exp_l [6];
    logic [1:0] exp_m [6];
    exp_l = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010};
    exp_m = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    for (int i = 0; i < 6; i++) begin
      wl_a = (i < 4);
      wr_a = (i >= 4);
      next_edge();
      checks++;
      if (lights_a !== exp_l[i]) begin errors++; $display("FAIL sweep_lights[%0d]: got %b expected %b", i, lights_a, exp_l[i]); end
      checks++;
      if (mode_a !== exp_m[i]) begin errors++; $display("FAIL sweep_mode[%0d]: got %b expected %b", i, mode_a, exp_m[i]); end
    end
  endtask

  // Wind 01 held: hazard until the first tick (edge 4), then a one-hot walk
  // from bit 0 upward, advancing every 4th edge.
  task automatic test_r2l_walk();
    logic [7:0] exp_l;
    logic [1:0] exp_m;
    rst_b = 1'b1; wl_b = 1'b0; wr_b = 1'b1;
    next_edge();
    next_edge();
    rst_b = 1'b0;
    b_e = 0;
    for (int e = 1; e <= 40; e++) begin
      next_edge();
      b_e = e;
      exp_l = (e < 4) ? 8'hFF : 8'(1 << ((e / 4 - 1) % 8));
      exp_m = (e < 4) ? 2'b11 : 2'b01;
      checks++;
      if (lights_b !== exp_l) begin errors++; $display("FAIL r2l_lights[e%0d]: got %h expected %h", e, lights_b, exp_l); end
      checks++;
      if (mode_b !== exp_m) begin errors++; $display("FAIL r2l_mode[e%0d]: got %b expected %b", e, mode_b, exp_m); end
      checks++;
      if (step_b !== ((e % 4) == 0)) begin errors++; $display("FAIL r2l_step[e%0d]: got %b expected %b", e, step_b, (e % 4) == 0); end
    end
  endtask

  // Inputs wander on non-tick cycles and are back at 01 for the tick cycle.
  task automatic test_glitch();
    logic [1:0] winds [4];
    logic [7:0] exp_l [4];
    winds = '{2'b10, 2'b11, 2'b00, 2'b01};
    exp_l = '{8'h02, 8'h02, 8'h02, 8'h04};
    for (int i = 0; i < 4; i++) begin
      {wl_b, wr_b} = winds[i];
      next_edge();
      b_e++;
      checks++;
      if (lights_b !== exp_l[i]) begin errors++; $display("FAIL glitch_lights[e%0d]: got %h expected %h", b_e, lights_b, exp_l[i]); end
      checks++;
      if (mode_b !== 2'b01) begin errors++; $display("FAIL glitch_mode[e%0d]: got %b expected 01", b_e, mode_b); end
      checks++;
      if (step_b !== (i == 3)) begin errors++; $display("FAIL glitch_step[e%0d]: got %b expected %b", b_e, step_b, i == 3); end
    end
  endtask

  task automatic test_solid_hazard();
    logic [7:0] exp_l;
    logic [1:0] exp_m;
    wl_b = 1'b1; wr_b = 1'b1;
    for (int e = 45; e <= 52; e++) begin
      next_edge();
      b_e = e;
      exp_l = (e < 48) ? 8'h04 : 8'hFF;
      exp_m = (e < 48) ? 2'b01 : 2'b11;
      checks++;
      if (lights_b !== exp_l) begin errors++; $display("FAIL solid_lights[e%0d]: got %h expected %h", e, lights_b, exp_l); end
      checks++;
      if (mode_b !== exp_m) begin errors++; $display("FAIL solid_mode[e%0d]: got %b expected %b", e, mode_b, exp_m); end
      checks++;
      if (step_b !== ((e % 4) == 0)) begin errors++; $display("FAIL solid_step[e%0d]: got %b expected %b", e, step_b, (e % 4) == 0); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    wl_b = 1'b1; wr_b = 1'b0;
    for (int e = 53; e <= 62; e++) begin
      next_edge();
      b_e = e;
      if (e == 56) begin
        checks++;
        if (lights_b !== 8'h80 || mode_b !== 2'b10) begin errors++; $display("FAIL l2r_entry: got %h/%b expected 80/10", lights_b, mode_b); end
      end
      if (e == 60) begin
        checks++;
        if (lights_b !== 8'h40) begin errors++; $display("FAIL l2r_shift: got %h expected 40", lights_b); end
      end
    end
    // Divider is at 2 here: reset lands mid-sweep and mid-divide.
    rst_b = 1'b1;
    next_edge();
    checks++;
    if (lights_b !== 8'hFF || mode_b !== 2'b11 || step_b !== 1'b0) begin
      errors++; $display("FAIL midreset_state: got %h/%b/%b expected ff/11/0", lights_b, mode_b, step_b);
    end
    rst_b = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      next_edge();
      checks++;
      if (k < 4) begin
        if (lights_b !== 8'hFF || mode_b !== 2'b11 || step_b !== 1'b0) begin
          errors++; $display("FAIL midreset_hold[%0d]: got %h/%b/%b expected ff/11/0", k, lights_b, mode_b, step_b);
        end
      end else begin
        if (lights_b !== 8'h80 || mode_b !== 2'b10 || step_b !== 1'b1) begin
          errors++; $display("FAIL midreset_first_tick: got %h/%b/%b expected 80/10/1", lights_b, mode_b, step_b);
        end
      end
    end
  endtask

  task automatic test_blink_hazard();
    logic [7:0] exp_l [3];
    exp_l = '{8'hFF, 8'h00, 8'hFF};
    rst_c = 1'b1; wl_c = 1'b0; wr_c = 1'b0;
    next_edge();
    next_edge();
    rst_c = 1'b0;
    next_edge();
    checks++;
    if (lights_c !== 8'hAA || mode_c !== 2'b00) begin errors++; $display("FAIL blink_calm: got %h/%b expected aa/00", lights_c, mode_c); end
    wl_c = 1'b1; wr_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_edge();
      checks++;
      if (lights_c !== exp_l[i]) begin errors++; $display("FAIL blink_lights[%0d]: got %h expected %h", i, lights_c, exp_l[i]); end
      checks++;
      if (mode_c !== 2'b11 || step_c !== 1'b1) begin errors++; $display("FAIL blink_mode_step[%0d]: got %b/%b expected 11/1", i, mode_c, step_c); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    b_e = 0;
    rst_a = 1'b1; wl_a = 1'b0; wr_a = 1'b0;
    rst_b = 1'b1; wl_b = 1'b0; wr_b = 1'b0;
    rst_c = 1'b1; wl_c = 1'b0; wr_c = 1'b0;
    test_reset();
    test_calm();
    test_sweep_reverse();
    test_r2l_walk();
    test_glitch();
    test_solid_hazard();
    test_reset_mid_sweep();
    test_blink_hazard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
